// File: rtl/rr_arbiter.sv
// Round-robin arbiter driving a mux select over NUM_INPUTS valid/ready requesters.
// A stalled grant is held until the downstream consumer accepts it.
module rr_arbiter #(
   parameter int NUM_INPUTS = 4,
   localparam int SELECT_BITS = $clog2(NUM_INPUTS)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_INPUTS-1:0]  i_valid,
   output logic [NUM_INPUTS-1:0]  o_ready,
   output logic [NUM_INPUTS-1:0]  o_grant,
   output logic [SELECT_BITS-1:0] o_select,
   output logic                   o_valid,
   input  logic                   i_ready
);

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } mode_e;

   localparam logic [SELECT_BITS:0]   NUM_W    = (SELECT_BITS+1)'(NUM_INPUTS);
   localparam logic [SELECT_BITS-1:0] LAST_IDX = SELECT_BITS'(NUM_INPUTS - 1);

   mode_e                  r_mode;
   mode_e                  w_modeNext;
   logic [SELECT_BITS-1:0] r_ptr;
   logic [SELECT_BITS-1:0] w_ptrNext;
   logic [SELECT_BITS-1:0] r_heldIdx;
   logic [SELECT_BITS-1:0] w_heldNext;

   logic [SELECT_BITS:0]   w_cand;
   logic [SELECT_BITS-1:0] w_arbIdx;
   logic                   w_found;
   logic [SELECT_BITS-1:0] w_grantIdx;
   logic                   w_hasGrant;
   logic                   w_transfer;
   logic                   w_stall;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_mode    <= ARB;
         r_ptr     <= '0;
         r_heldIdx <= '0;
      end else begin
         r_mode    <= w_modeNext;
         r_ptr     <= w_ptrNext;
         r_heldIdx <= w_heldNext;
      end
   end

   // Rotating search: first valid index at or after r_ptr, wrapping modulo NUM_INPUTS.
   always_comb begin
      w_found  = 1'b0;
      w_arbIdx = '0;
      w_cand   = '0;
      for (int off = 0; off < NUM_INPUTS; off++) begin
         w_cand = {1'b0, r_ptr} + (SELECT_BITS+1)'(off);
         if (w_cand >= NUM_W) begin
            w_cand = w_cand - NUM_W;
         end
         if (!w_found && i_valid[w_cand[SELECT_BITS-1:0]]) begin
            w_found  = 1'b1;
            w_arbIdx = w_cand[SELECT_BITS-1:0];
         end
      end
   end

   always_comb begin
      w_grantIdx = (r_mode == HOLD) ? r_heldIdx : w_arbIdx;
      w_hasGrant = i_rst_n && ((r_mode == HOLD) || w_found);
      o_grant    = '0;
      o_select   = '0;
      o_valid    = 1'b0;
      if (w_hasGrant) begin
         o_grant[w_grantIdx] = 1'b1;
         o_select            = w_grantIdx;
         o_valid             = i_valid[w_grantIdx];
      end
      o_ready    = o_grant & {NUM_INPUTS{i_ready}};
      w_transfer = o_valid && i_ready;
      w_stall    = o_valid && !i_ready;
   end

   // A held requester that drops its valid simply releases the lock with ptr untouched.
   always_comb begin
      w_modeNext = r_mode;
      w_ptrNext  = r_ptr;
      w_heldNext = r_heldIdx;
      if (w_transfer) begin
         w_modeNext = ARB;
         w_ptrNext  = (w_grantIdx == LAST_IDX) ? '0 : w_grantIdx + 1'b1;
      end else if (w_stall) begin
         w_modeNext = HOLD;
         w_heldNext = w_grantIdx;
      end else if (r_mode == HOLD) begin
         w_modeNext = ARB;
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed testbench for rr_arbiter with six requesters, plus a randomised fairness run.
module tb_rr_arbiter;

   localparam int N = 6;

   logic         clock;
   logic         rstN;
   logic [N-1:0] valid;
   logic [N-1:0] readyOut;
   logic [N-1:0] grant;
   logic [2:0]   select;
   logic         validOut;
   logic         readyIn;

   int checks = 0;
   int errors = 0;

   rr_arbiter #(.NUM_INPUTS(N)) dut (
      .i_clk   (clock),
      .i_rst_n (rstN),
      .i_valid (valid),
      .o_ready (readyOut),
      .o_grant (grant),
      .o_select(select),
      .o_valid (validOut),
      .i_ready (readyIn)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic rd);
      rstN    = r;
      valid   = v;
      readyIn = rd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [N-1:0] g, input logic [N-1:0] r,
                           input logic [2:0] s, input logic v);
      checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
      checkOutput({tag, ".ready"}, 32'(readyOut), 32'(r));
      checkOutput({tag, ".select"}, 32'(select), 32'(s));
      checkOutput({tag, ".valid"}, 32'(validOut), 32'(v));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [N-1:0] oneHot;
      logic [N-1:0] randValid;
      logic         randReady;
      int           otherCnt;
      int           grants2;

      // Reset for two edges, then a lone request on index 2.
      applyStimulus(1'b0, 6'b000100, 1'b1);
      checkAll("rst0", 6'b0, 6'b0, 3'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 6'b000100, 1'b1);
      checkAll("rst1", 6'b0, 6'b0, 3'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 6'b000100, 1'b1);
      checkAll("single", 6'b000100, 6'b000100, 3'd2, 1'b1);
      tick();

      // ptr should now be 3, so index 3 beats index 0.
      applyStimulus(1'b1, 6'b001001, 1'b1);
      checkAll("ptr3", 6'b001000, 6'b001000, 3'd3, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b100000, 1'b1);
      checkAll("wrap5", 6'b100000, 6'b100000, 3'd5, 1'b1);
      tick();

      for (int i = 0; i < 8; i++) begin
         oneHot = 6'b000001 << (i % N);
         applyStimulus(1'b1, 6'b111111, 1'b1);
         checkAll($sformatf("rot%0d", i), oneHot, oneHot, 3'(i % N), 1'b1);
         tick();
      end

      // ptr is 2 after rotation; a transfer on 5 brings it back to 0.
      applyStimulus(1'b1, 6'b100000, 1'b1);
      checkAll("to0", 6'b100000, 6'b100000, 3'd5, 1'b1);
      tick();

      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6'b100010, 1'b0);
         checkAll($sformatf("stall%0d", i), 6'b000010, 6'b0, 3'd1, 1'b1);
         tick();
      end
      applyStimulus(1'b1, 6'b100011, 1'b0);
      checkAll("stallRaise0", 6'b000010, 6'b0, 3'd1, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b100011, 1'b1);
      checkAll("stallXfer", 6'b000010, 6'b000010, 3'd1, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b100001, 1'b1);
      checkAll("after1", 6'b100000, 6'b100000, 3'd5, 1'b1);
      tick();

      // Protocol drop: lock on 3 with ptr 3, then requester 3 withdraws.
      applyStimulus(1'b1, 6'b000100, 1'b1);
      checkAll("setPtr3", 6'b000100, 6'b000100, 3'd2, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b011000, 1'b0);
      checkAll("lock3", 6'b001000, 6'b0, 3'd3, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b010000, 1'b0);
      checkOutput("drop.valid", 32'(validOut), 32'(1'b0));
      tick();
      applyStimulus(1'b1, 6'b010001, 1'b1);
      checkAll("afterDrop", 6'b010000, 6'b010000, 3'd4, 1'b1);
      tick();

      // Reset in the middle of a HOLD on index 4 with ptr 4.
      applyStimulus(1'b1, 6'b001000, 1'b1);
      checkAll("setPtr4", 6'b001000, 6'b001000, 3'd3, 1'b1);
      tick();
      applyStimulus(1'b1, 6'b010000, 1'b0);
      checkAll("lock4", 6'b010000, 6'b0, 3'd4, 1'b1);
      tick();
      applyStimulus(1'b0, 6'b111111, 1'b0);
      checkAll("rstHold", 6'b0, 6'b0, 3'd0, 1'b0);
      tick();
      applyStimulus(1'b1, 6'b111111, 1'b1);
      checkAll("postRst", 6'b000001, 6'b000001, 3'd0, 1'b1);
      tick();

      // Requester 2 stays valid; everyone else and i_ready are random.
      otherCnt = 0;
      grants2  = 0;
      for (int c = 0; c < 300; c++) begin
         randValid = N'($urandom) | 6'b000100;
         randReady = 1'($urandom_range(0, 1));
         applyStimulus(1'b1, randValid, randReady);
         checkOutput("fair.onehot", 32'($onehot0(grant)), 32'd1);
         checkOutput("fair.ready", 32'(readyOut), 32'(grant & {N{randReady}}));
         if (validOut && randReady) begin
            if (grant == 6'b000100) begin
               checkOutput("fair.bound", 32'(otherCnt <= N - 1), 32'd1);
               grants2++;
               otherCnt = 0;
            end else begin
               otherCnt++;
            end
         end
         tick();
      end
      checkOutput("fair.served", 32'(grants2 > 0), 32'd1);
      checkOutput("fair.pending", 32'(otherCnt <= N - 1), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
